// File: rtl/mem_stream_pkg.sv
// Shared types and default sizes for the row streamer and its output buffer.
// Optional feature macro used by the streamer: MEM_STREAM_LAST_EN.
package mem_stream_pkg;

    localparam int ELEMENT_WIDTH_DEF = 32;
    localparam int ADDRESS_WIDTH_DEF = 20;
    localparam int NO_OF_UNITS_DEF   = 8;

    // Number of rows the output buffer can hold.
    localparam logic [1:0] FIFO_DEPTH = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry valid/ready buffer between the memory read port and the output stream.
// When MEM_STREAM_LAST_EN is defined the top level widens DATA_WIDTH by one bit
// to carry the last-row flag alongside each row.
module stream_skid_fifo
    import mem_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_pop,
    output logic [1:0]            o_count
);

    logic [DATA_WIDTH-1:0] r_data0;
    logic [DATA_WIDTH-1:0] r_data1;
    logic [1:0]            r_count;
    logic                  w_pop;

    assign w_pop   = (r_count != 2'd0) && i_ready;
    assign o_pop   = w_pop;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_data0;
    assign o_count = r_count;

    // Head register feeds the stream; a pop shifts the second entry forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_data0 <= i_data;
                    else                 r_data1 <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_data0 <= i_data;
                    end else begin
                        r_data0 <= r_data1;
                        r_data1 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_row_streamer.sv
// Walks a contiguous row range of a combinational-read memory and streams the
// rows over valid/ready, finishing with a one-cycle pulse.
// Optional macro MEM_STREAM_LAST_EN adds o_out_last on the final row's beat.
module mem_row_streamer
    import mem_stream_pkg::*;
#(
    parameter int ELEMENT_WIDTH = ELEMENT_WIDTH_DEF,
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int NO_OF_UNITS   = NO_OF_UNITS_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_start,
    input  logic [ADDRESS_WIDTH-1:0]             i_base_address,
    input  logic [ADDRESS_WIDTH-1:0]             i_length,
    output logic [ADDRESS_WIDTH-1:0]             o_mem_read_address,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] i_mem_read_data,
    output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] o_out_data,
    output logic                                 o_out_valid,
    input  logic                                 i_out_ready,
`ifdef MEM_STREAM_LAST_EN
    output logic                                 o_out_last,
`endif
    output logic                                 o_busy,
    output logic                                 o_finish
);

    localparam int ROW_WIDTH = NO_OF_UNITS * ELEMENT_WIDTH;
`ifdef MEM_STREAM_LAST_EN
    localparam int FIFO_WIDTH = ROW_WIDTH + 1;
`else
    localparam int FIFO_WIDTH = ROW_WIDTH;
`endif
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    state_t                   r_state;
    state_t                   w_next_state;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [ADDRESS_WIDTH-1:0] r_remaining;
    logic                     r_busy;
    logic                     r_finish;
    logic                     w_accept;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_fifo_valid;
    logic [1:0]               w_fifo_count;
    logic [FIFO_WIDTH-1:0]    w_fifo_in;
    logic [FIFO_WIDTH-1:0]    w_fifo_out;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state decision: leave STREAM on the last push, leave DRAIN on the last pop.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:   if (i_start) w_next_state = (i_length == '0) ? DONE : STREAM;
            STREAM: if (w_push && (r_remaining == ADDR_ONE)) w_next_state = DRAIN;
            DRAIN:  if ((w_fifo_count == 2'd0) || ((w_fifo_count == 2'd1) && w_pop))
                        w_next_state = DONE;
            DONE:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode: accept a start only in IDLE, push while rows remain and space exists.
    always_comb begin
        w_accept = (r_state == IDLE) && i_start;
        w_push   = (r_state == STREAM) && ((w_fifo_count < FIFO_DEPTH) || w_pop) &&
                   (r_remaining != '0);
    end

    // Address and remaining-row counters; the address wraps naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (w_accept) begin
            r_addr      <= i_base_address;
            r_remaining <= i_length;
        end else if (w_push) begin
            r_addr      <= r_addr + ADDR_ONE;
            r_remaining <= r_remaining - ADDR_ONE;
        end
    end

    // Busy and finish track the state the FSM is about to enter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_busy   <= (w_next_state != IDLE);
            r_finish <= (w_next_state == DONE);
        end
    end

`ifdef MEM_STREAM_LAST_EN
    assign w_fifo_in  = {(r_remaining == ADDR_ONE), i_mem_read_data};
    assign o_out_last = w_fifo_out[ROW_WIDTH] && w_fifo_valid;
`else
    assign w_fifo_in  = i_mem_read_data;
`endif

    stream_skid_fifo #(
        .DATA_WIDTH (FIFO_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_fifo_in),
        .i_ready (i_out_ready),
        .o_data  (w_fifo_out),
        .o_valid (w_fifo_valid),
        .o_pop   (w_pop),
        .o_count (w_fifo_count)
    );

    assign o_mem_read_address = r_addr;
    assign o_out_data         = w_fifo_out[ROW_WIDTH-1:0];
    assign o_out_valid        = w_fifo_valid;
    assign o_busy             = r_busy;
    assign o_finish           = r_finish;

endmodule

// File: tb/tb_mem_row_streamer.sv
// Directed bench for mem_row_streamer; honours MEM_STREAM_LAST_EN when defined.
module tb_mem_row_streamer;

    logic          clk;
    logic          rstN;
    logic          startIn;
    logic [19:0]   baseIn;
    logic [19:0]   lenIn;
    logic [19:0]   memReadAddress;
    logic [255:0]  memReadData;
    logic [255:0]  outData;
    logic          outValid;
    logic          outReady;
    logic          outBusy;
    logic          outFinish;
`ifdef MEM_STREAM_LAST_EN
    logic          outLast;
`endif

    int checks = 0;
    int errors = 0;

    // Memory model: every element of row a holds the address a.
    function automatic logic [255:0] rowOf(input logic [19:0] a);
        return {8{{12'b0, a}}};
    endfunction

    assign memReadData = rowOf(memReadAddress);

    mem_row_streamer dut (
        .clk                (clk),
        .rst_n              (rstN),
        .i_start            (startIn),
        .i_base_address     (baseIn),
        .i_length           (lenIn),
        .o_mem_read_address (memReadAddress),
        .i_mem_read_data    (memReadData),
        .o_out_data         (outData),
        .o_out_valid        (outValid),
        .i_out_ready        (outReady),
`ifdef MEM_STREAM_LAST_EN
        .o_out_last         (outLast),
`endif
        .o_busy             (outBusy),
        .o_finish           (outFinish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case a wait is ever left unbounded.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one sampled edge; returns at the falling edge of cycle k+1.
    task automatic applyStimulus(input logic [19:0] base, input logic [19:0] len);
        @(negedge clk);
        startIn = 1'b1;
        baseIn  = base;
        lenIn   = len;
        @(negedge clk);
        startIn = 1'b0;
    endtask

    initial begin
        logic [19:0]  expAddr;
        logic [255:0] prevData;
        logic         prevValid;
        logic         prevReady;
        logic         seenFinish;
        int           accepted;
        int           lead;

        rstN     = 1'b0;
        startIn  = 1'b0;
        baseIn   = '0;
        lenIn    = '0;
        outReady = 1'b1;

        #1;
        checkOutput("reset_outputs", 256'({memReadAddress, outData, outValid, outBusy, outFinish}), 256'(0));
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_outputs", 256'({memReadAddress, outData, outValid, outBusy, outFinish}), 256'(0));
        end

        $display("[TB] basic stream base=5 length=4");
        applyStimulus(20'd5, 20'd4);
        checkOutput("basic_k1_busy", 256'(outBusy), 256'(1));
        checkOutput("basic_k1_valid", 256'(outValid), 256'(0));
        checkOutput("basic_k1_addr", 256'(memReadAddress), 256'(5));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("basic_valid", 256'(outValid), 256'(1));
            checkOutput("basic_row", outData, rowOf(20'(5 + i)));
            checkOutput("basic_finish_low", 256'(outFinish), 256'(0));
`ifdef MEM_STREAM_LAST_EN
            checkOutput("basic_last", 256'(outLast), 256'(i == 3));
`endif
        end
        @(negedge clk);
        checkOutput("basic_finish", 256'(outFinish), 256'(1));
        checkOutput("basic_finish_busy", 256'(outBusy), 256'(1));
        checkOutput("basic_finish_valid", 256'(outValid), 256'(0));
        checkOutput("basic_addr_hold", 256'(memReadAddress), 256'(9));
        @(negedge clk);
        checkOutput("basic_after_finish", 256'({outFinish, outBusy}), 256'(0));

        $display("[TB] zero length");
        applyStimulus(20'd7, 20'd0);
        checkOutput("zero_finish", 256'(outFinish), 256'(1));
        checkOutput("zero_busy", 256'(outBusy), 256'(1));
        checkOutput("zero_valid", 256'(outValid), 256'(0));
        @(negedge clk);
        checkOutput("zero_after", 256'({outFinish, outBusy, outValid}), 256'(0));

        $display("[TB] address wrap");
        applyStimulus(20'hFFFFE, 20'd4);
        checkOutput("wrap_k1_addr", 256'(memReadAddress), 256'(20'hFFFFE));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            expAddr = 20'hFFFFE + 20'(i);
            checkOutput("wrap_valid", 256'(outValid), 256'(1));
            checkOutput("wrap_row", outData, rowOf(expAddr));
        end
        @(negedge clk);
        checkOutput("wrap_finish", 256'(outFinish), 256'(1));
        checkOutput("wrap_addr_hold", 256'(memReadAddress), 256'(2));

        $display("[TB] backpressure base=0 length=6");
        @(negedge clk);
        applyStimulus(20'd0, 20'd6);
        accepted   = 0;
        prevValid  = 1'b0;
        prevReady  = 1'b1;
        prevData   = '0;
        seenFinish = 1'b0;
        for (int c = 0; c < 60 && !seenFinish; c++) begin
            if (c > 0) @(negedge clk);
            outReady = ((c % 4) == 0) || ((c % 4) == 3);
            if (prevValid && !prevReady)
                checkOutput("bp_stall_stable", outData, prevData);
            lead = int'(memReadAddress) - accepted;
            checkOutput("bp_lead_le2", 256'((lead >= 0) && (lead <= 2)), 256'(1));
            if (outValid && outReady) begin
                checkOutput("bp_row", outData, rowOf(20'(accepted)));
                accepted++;
            end
            if (outFinish) seenFinish = 1'b1;
            prevValid = outValid;
            prevData  = outData;
            prevReady = outReady;
        end
        checkOutput("bp_finish_seen", 256'(seenFinish), 256'(1));
        checkOutput("bp_row_count", 256'(accepted), 256'(6));
        outReady = 1'b1;

        $display("[TB] ignored start and reset mid-transfer");
        @(negedge clk);
        applyStimulus(20'd10, 20'd8);
        @(negedge clk);
        checkOutput("mid_row10", outData, rowOf(20'd10));
        startIn = 1'b1;
        baseIn  = 20'd100;
        lenIn   = 20'd1;
        @(negedge clk);
        startIn = 1'b0;
        checkOutput("mid_row11", outData, rowOf(20'd11));
        checkOutput("mid_addr", 256'(memReadAddress), 256'(12));
        checkOutput("mid_busy", 256'(outBusy), 256'(1));
        @(negedge clk);
        checkOutput("mid_row12", outData, rowOf(20'd12));
        rstN = 1'b0;
        #1;
        checkOutput("mid_reset_valid", 256'(outValid), 256'(0));
        checkOutput("mid_reset_busy", 256'(outBusy), 256'(0));
        checkOutput("mid_reset_rest", 256'({memReadAddress, outData, outFinish}), 256'(0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) rstN = 1'b1;
            checkOutput("mid_no_finish", 256'({outFinish, outValid}), 256'(0));
        end

        applyStimulus(20'd3, 20'd3);
        checkOutput("fresh_k1_addr", 256'(memReadAddress), 256'(3));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("fresh_valid", 256'(outValid), 256'(1));
            checkOutput("fresh_row", outData, rowOf(20'(3 + i)));
`ifdef MEM_STREAM_LAST_EN
            checkOutput("fresh_last", 256'(outLast), 256'(i == 2));
`endif
        end
        @(negedge clk);
        checkOutput("fresh_finish", 256'(outFinish), 256'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
